// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Arbitration policy is selected by DM_ARB_RR_EN (round-robin when defined).
package dm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } dm_arb_state_t;

   localparam int DM_ADDR_W = 32;
   localparam int DM_DATA_W = 32;
   localparam int DM_DEPTH  = 10001;

   // Word-address memory map of the data memory.
   localparam int DM_TEXT_BASE   = 40;
   localparam int DM_STATIC_BASE = 1000;
   localparam int DM_DYN_BASE    = 2000;
   localparam int DM_STACK_TOP   = 10000;

endpackage

// File: rtl/dm_arb_pick.sv
// Two-way one-hot picker for the data-memory arbiter.
// DM_ARB_RR_EN: round-robin on ties; otherwise requester 0 has fixed priority.
module dm_arb_pick (
`ifdef DM_ARB_RR_EN
   input  logic       last,
`endif
   input  logic [1:0] req,
   output logic [1:0] win
);

   always_comb begin
      win = 2'b00;
`ifdef DM_ARB_RR_EN
      // On a tie the requester that did not win last time goes first.
      if (req == 2'b11)
         win = last ? 2'b01 : 2'b10;
      else
         win = req;
`else
      if (req[0])
         win = 2'b01;
      else if (req[1])
         win = 2'b10;
`endif
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port request/grant arbiter in front of the single-ported data memory.
// DM_ARB_RR_EN selects round-robin arbitration instead of fixed priority.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int ADDR_W = DM_ADDR_W,
   parameter int DATA_W = DM_DATA_W,
   parameter int DEPTH  = DM_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req,
   input  logic [1:0]          we,
   input  logic [2*ADDR_W-1:0] addr,
   input  logic [2*DATA_W-1:0] wdata,
   output logic [1:0]          gnt,
   output logic [1:0]          ack,
   output logic                err,
   output logic [DATA_W-1:0]   rdata,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic                m_memWrite,
   output logic                m_memRead,
   input  logic [DATA_W-1:0]   m_rdata
);

   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

   dm_arb_state_t state, nxt;

   logic [1:0]        pick;
   logic [1:0]        win;
   logic              sel;
   logic              we_sel;
   logic              oor_sel;
   logic [ADDR_W-1:0] a_sel;
   logic [DATA_W-1:0] d_sel;
   logic              we_q;
   logic              oor_q;

`ifdef DM_ARB_RR_EN
   logic last;

   dm_arb_pick u_pick (
      .last (last),
      .req  (req),
      .win  (pick)
   );
`else
   dm_arb_pick u_pick (
      .req  (req),
      .win  (pick)
   );
`endif

   assign sel    = pick[1];
   assign we_sel = we[sel];
   assign a_sel  = sel ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
   assign d_sel  = sel ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
   // Full-width unsigned compare: no wrap of large addresses into range.
   assign oor_sel = {1'b0, a_sel} >= DEPTH_V;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    nxt = (|req) ? ACCESS : IDLE;
         ACCESS:  nxt = RESP;
         RESP:    nxt = (|req) ? ACCESS : IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt        <= '0;
         ack        <= '0;
         err        <= 1'b0;
         rdata      <= '0;
         m_addr     <= '0;
         m_wdata    <= '0;
         m_memWrite <= 1'b0;
         m_memRead  <= 1'b0;
         win        <= '0;
         we_q       <= 1'b0;
         oor_q      <= 1'b0;
`ifdef DM_ARB_RR_EN
         last       <= 1'b1;
`endif
      end else begin
         gnt        <= '0;
         ack        <= '0;
         err        <= 1'b0;
         m_memWrite <= 1'b0;
         m_memRead  <= 1'b0;
         if (state == ACCESS) begin
            ack   <= win;
            err   <= oor_q;
            rdata <= (!we_q && !oor_q) ? m_rdata : '0;
         end
         if (nxt == ACCESS) begin
            gnt        <= pick;
            win        <= pick;
            we_q       <= we_sel;
            oor_q      <= oor_sel;
            m_addr     <= a_sel;
            m_wdata    <= d_sel;
            m_memWrite <= we_sel && !oor_sel;
            m_memRead  <= !we_sel && !oor_sel;
`ifdef DM_ARB_RR_EN
            last       <= sel;
`endif
         end
      end
   end

endmodule
